// File: rtl/mania_pkg.sv
// rtl/mania_pkg.sv - shared encodings and constants for the 4-lane rhythm game sequencer
package mania_pkg;

  localparam int SCREEN_H      = 480;
  localparam int SCORE_PERFECT = 300;
  localparam int SCORE_GOOD    = 100;

  // Numeric order doubles as severity, so the worst judgement is the maximum code
  typedef enum logic [1:0] {
    J_NONE    = 2'd0,
    J_PERFECT = 2'd1,
    J_GOOD    = 2'd2,
    J_MISS    = 2'd3
  } judge_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_RUN,
    ST_DONE
  } state_e;

  function automatic logic [SCREEN_H-1:0] row_mask(input int lo, input int hi);
    logic [SCREEN_H-1:0] m;
    m = '0;
    for (int i = 0; i < SCREEN_H; i++) begin
      if (i >= lo && i <= hi) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/lane_judge.sv
// rtl/lane_judge.sv - one lane: note bitmap scroll, spawn, hit window judge and miss detect
module lane_judge
  import mania_pkg::*;
#(
  parameter int SPEED       = 4,
  parameter int NOTE_H      = 16,
  parameter int JUDGE_ROW   = 440,
  parameter int PERFECT_WIN = 8,
  parameter int GOOD_WIN    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                judge_en,
  input  logic                shift,
  input  logic                spawn,
  input  logic                press,
  output logic [SCREEN_H-1:0] track,
  output judge_e              code
);

  localparam logic [SCREEN_H-1:0] PERFECT_MASK =
    row_mask(JUDGE_ROW - PERFECT_WIN, JUDGE_ROW + PERFECT_WIN - 1);
  localparam logic [SCREEN_H-1:0] GOOD_MASK =
    row_mask(JUDGE_ROW - GOOD_WIN, JUDGE_ROW + GOOD_WIN - 1);
  localparam logic [SCREEN_H-1:0] CLEAR_MASK = row_mask(JUDGE_ROW - GOOD_WIN, SCREEN_H - 1);
  localparam logic [SCREEN_H-1:0] SPAWN_MASK = row_mask(0, NOTE_H - 1);

  logic                perfect_hit;
  logic                good_hit;
  logic                miss;
  logic [SCREEN_H-1:0] kept;
  logic [SCREEN_H-1:0] shifted;
  logic [SCREEN_H-1:0] track_next;

  // Hit clear is applied before the shift so a same-cycle tick cannot bring cleared rows back
  always_comb begin
    perfect_hit = judge_en && press && (|(track & PERFECT_MASK));
    good_hit    = judge_en && press && !perfect_hit && (|(track & GOOD_MASK));
    kept        = (perfect_hit || good_hit) ? (track & ~CLEAR_MASK) : track;
    shifted     = shift ? (kept << SPEED) : kept;
    track_next  = spawn ? (shifted | SPAWN_MASK) : shifted;
    miss        = shift && shifted[SCREEN_H-1] && !track[SCREEN_H-1];
    code        = J_NONE;
    if (perfect_hit)   code = J_PERFECT;
    else if (good_hit) code = J_GOOD;
    else if (miss)     code = J_MISS;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      track <= '0;
    end else if (clear) begin
      track <= '0;
    end else begin
      track <= track_next;
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - chart walker, lane scroll control and score/combo accounting
module note_scheduler
  import mania_pkg::*;
#(
  parameter int SPEED       = 4,
  parameter int NOTE_H      = 16,
  parameter int JUDGE_ROW   = 440,
  parameter int PERFECT_WIN = 8,
  parameter int GOOD_WIN    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                start,
  input  logic                stop,
  input  logic [3:0]          key_press,
  output logic [9:0]          rom_addr,
  input  logic [19:0]         rom_data,
  output logic [SCREEN_H-1:0] track0,
  output logic [SCREEN_H-1:0] track1,
  output logic [SCREEN_H-1:0] track2,
  output logic [SCREEN_H-1:0] track3,
  output logic [19:0]         score,
  output logic [9:0]          combo,
  output logic                judge_valid,
  output logic [1:0]          judge_code,
  output logic                busy,
  output logic                done
);

  state_e              state, next_state;
  logic [15:0]         frame_cnt, frame_next;
  logic [15:0]         next_time;
  logic [3:0]          next_mask;
  logic                start_run, shift_en, spawn_en, latch_en, judge_en, clear_tracks;
  logic                tracks_empty;
  logic [SCREEN_H-1:0] lane_track [4];
  judge_e              lane_code [4];
  judge_e              worst;
  logic [10:0]         pts_sum;
  logic [2:0]          hit_cnt;
  logic                any_miss;
  logic [20:0]         score_sum;
  logic [10:0]         combo_sum;
  logic [19:0]         score_next;
  logic [9:0]          combo_next;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    lane_judge #(
      .SPEED      (SPEED),
      .NOTE_H     (NOTE_H),
      .JUDGE_ROW  (JUDGE_ROW),
      .PERFECT_WIN(PERFECT_WIN),
      .GOOD_WIN   (GOOD_WIN)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear_tracks),
      .judge_en(judge_en),
      .shift   (shift_en),
      .spawn   (spawn_en && next_mask[g]),
      .press   (key_press[g]),
      .track   (lane_track[g]),
      .code    (lane_code[g])
    );
  end

  assign track0       = lane_track[0];
  assign track1       = lane_track[1];
  assign track2       = lane_track[2];
  assign track3       = lane_track[3];
  assign tracks_empty = ~|{lane_track[0], lane_track[1], lane_track[2], lane_track[3]};
  assign busy         = (state == ST_FETCH) || (state == ST_RUN);
  assign done         = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // stop outranks every other event in the cycle, including ticks and presses
  always_comb begin
    next_state   = state;
    start_run    = 1'b0;
    shift_en     = 1'b0;
    spawn_en     = 1'b0;
    latch_en     = 1'b0;
    judge_en     = !stop && (state != ST_IDLE);
    frame_next   = frame_cnt + 16'd1;
    if (stop) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            start_run  = 1'b1;
            next_state = ST_FETCH;
          end
        end
        ST_FETCH: next_state = ST_WAIT;
        ST_WAIT: begin
          latch_en   = 1'b1;
          next_state = ST_RUN;
        end
        ST_RUN: begin
          shift_en = frame_tick;
          if (frame_tick && (frame_next == next_time) && (next_mask != 4'd0)) begin
            spawn_en   = 1'b1;
            next_state = ST_FETCH;
          end else if ((next_mask == 4'd0) && tracks_empty) begin
            next_state = ST_DONE;
          end
        end
        ST_DONE: next_state = ST_DONE;
        default: next_state = ST_IDLE;
      endcase
    end
    clear_tracks = stop || start_run;
  end

  always_comb begin
    pts_sum  = '0;
    hit_cnt  = '0;
    any_miss = 1'b0;
    worst    = J_NONE;
    for (int i = 0; i < 4; i++) begin
      case (lane_code[i])
        J_PERFECT: begin
          pts_sum = pts_sum + 11'(SCORE_PERFECT);
          hit_cnt = hit_cnt + 3'd1;
        end
        J_GOOD: begin
          pts_sum = pts_sum + 11'(SCORE_GOOD);
          hit_cnt = hit_cnt + 3'd1;
        end
        J_MISS:  any_miss = 1'b1;
        default: ;
      endcase
      if (lane_code[i] > worst) worst = lane_code[i];
    end
    score_sum  = {1'b0, score} + 21'(pts_sum);
    combo_sum  = {1'b0, combo} + 11'(hit_cnt);
    score_next = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
    combo_next = any_miss ? 10'd0 : (combo_sum[10] ? 10'd1023 : combo_sum[9:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr    <= '0;
      frame_cnt   <= '0;
      next_time   <= '0;
      next_mask   <= '0;
      score       <= '0;
      combo       <= '0;
      judge_valid <= 1'b0;
      judge_code  <= 2'd0;
    end else begin
      judge_valid <= (worst != J_NONE);
      judge_code  <= worst;
      if (start_run) begin
        rom_addr  <= '0;
        frame_cnt <= '0;
        score     <= '0;
        combo     <= '0;
      end else begin
        score <= score_next;
        combo <= combo_next;
        if (shift_en) frame_cnt <= frame_next;
        if (spawn_en) rom_addr <= rom_addr + 10'd1;
      end
      if (latch_en) begin
        next_time <= rom_data[19:4];
        next_mask <= rom_data[3:0];
      end
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// tb/tb_note_scheduler.sv - scoreboard bench for note_scheduler
module tb_note_scheduler;

  logic         clk;
  logic         rst;
  logic         frame_tick;
  logic         start;
  logic         stop;
  logic [3:0]   key_press;
  logic [9:0]   rom_addr;
  logic [19:0]  rom_data;
  logic [479:0] track0, track1, track2, track3;
  logic [19:0]  score;
  logic [9:0]   combo;
  logic         judge_valid;
  logic [1:0]   judge_code;
  logic         busy;
  logic         done;

  logic [19:0]  rom [0:1023];
  logic [1:0]   exp_q [$];
  logic [1:0]   exp_code;
  int           checks = 0;
  int           errors = 0;

  note_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .stop       (stop),
    .key_press  (key_press),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .track0     (track0),
    .track1     (track1),
    .track2     (track2),
    .track3     (track3),
    .score      (score),
    .combo      (combo),
    .judge_valid(judge_valid),
    .judge_code (judge_code),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // Every judgement pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst && judge_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL judge_unexpected got code=%0d expected no judgement", judge_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (judge_code !== exp_code) begin
          errors++;
          $display("FAIL judge_code got=%0d expected=%0d", judge_code, exp_code);
        end
      end
    end
  end

  function automatic logic [479:0] rows(input int lo, input int hi);
    logic [479:0] m;
    m = '0;
    for (int i = 0; i < 480; i++) if (i >= lo && i <= hi) m[i] = 1'b1;
    return m;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic press(input logic [3:0] lanes);
    key_press = lanes;
    cycle();
    key_press = 4'd0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 20'h0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
  endtask

  task automatic begin_chart();
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cycle();
    checks++;
    if ((track0 | track1 | track2 | track3) !== '0) begin
      errors++;
      $display("FAIL reset_tracks got nonzero expected all zero");
    end
    checks++;
    if ({score, combo, rom_addr, judge_valid, judge_code, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got score=%0d combo=%0d addr=%0d jv=%0b jc=%0d busy=%0b done=%0b expected all 0",
               score, combo, rom_addr, judge_valid, judge_code, busy, done);
    end
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_spawn();
    clear_rom();
    rom[0] = {16'd3, 4'b0001};
    do_reset();
    begin_chart();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL spawn_busy got=%0b expected=1", busy);
    end
    repeat (3) tick();
    checks++;
    if (track0 !== rows(0, 15)) begin
      errors++;
      $display("FAIL spawn_track0 got=%h expected=%h", track0, rows(0, 15));
    end
    checks++;
    if ((track1 | track2 | track3) !== '0 || rom_addr !== 10'd1) begin
      errors++;
      $display("FAIL spawn_others got addr=%0d other_tracks_zero=%0b expected addr=1 zero=1",
               rom_addr, (track1 | track2 | track3) == '0);
    end
    tick();
    checks++;
    if (track0 !== rows(4, 19)) begin
      errors++;
      $display("FAIL spawn_scroll got=%h expected=%h", track0, rows(4, 19));
    end
  endtask

  task automatic test_perfect();
    clear_rom();
    rom[0] = {16'd1, 4'b0001};
    do_reset();
    begin_chart();
    repeat (110) tick();
    checks++;
    if (track0 !== rows(436, 451)) begin
      errors++;
      $display("FAIL perfect_pos got=%h expected=%h", track0, rows(436, 451));
    end
    exp_q.push_back(2'd1);
    press(4'b0001);
    checks++;
    if (score !== 20'd300 || combo !== 10'd1) begin
      errors++;
      $display("FAIL perfect_score got score=%0d combo=%0d expected 300/1", score, combo);
    end
    checks++;
    if (track0 !== '0 || judge_valid !== 1'b1 || judge_code !== 2'd1) begin
      errors++;
      $display("FAIL perfect_clear got jv=%0b jc=%0d track0_zero=%0b expected 1/1/1",
               judge_valid, judge_code, track0 == '0);
    end
    cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL perfect_pending got=%0d outstanding expected=0", exp_q.size());
    end
  endtask

  task automatic test_good_and_ignored();
    clear_rom();
    rom[0] = {16'd1, 4'b0001};
    do_reset();
    begin_chart();
    repeat (98) tick();
    press(4'b0001);
    checks++;
    if (score !== 20'd0 || combo !== 10'd0 || judge_valid !== 1'b0 || track0 !== rows(388, 403)) begin
      errors++;
      $display("FAIL ignored_press got score=%0d combo=%0d jv=%0b expected 0/0/0 and track kept",
               score, combo, judge_valid);
    end
    repeat (5) tick();
    exp_q.push_back(2'd2);
    press(4'b0001);
    checks++;
    if (score !== 20'd100 || combo !== 10'd1) begin
      errors++;
      $display("FAIL good_score got score=%0d combo=%0d expected 100/1", score, combo);
    end
    checks++;
    if (track0 !== rows(408, 415)) begin
      errors++;
      $display("FAIL good_clear got=%h expected=%h", track0, rows(408, 415));
    end
    cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL good_pending got=%0d outstanding expected=0", exp_q.size());
    end
  endtask

  task automatic test_miss();
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = {16'(1 + 16 * i), 4'b0001};
    rom[5] = {16'd81, 4'b0100};
    do_reset();
    begin_chart();
    for (int f = 1; f <= 200; f++) begin
      if (f == 197) exp_q.push_back(2'd3);
      tick();
      if (f >= 110 && f <= 174 && ((f - 110) % 16) == 0) begin
        exp_q.push_back(2'd1);
        press(4'b0001);
      end
      if (f == 196) begin
        checks++;
        if (combo !== 10'd5 || score !== 20'd1500) begin
          errors++;
          $display("FAIL miss_before got combo=%0d score=%0d expected 5/1500", combo, score);
        end
      end
      if (f == 197) begin
        checks++;
        if (combo !== 10'd0 || score !== 20'd1500) begin
          errors++;
          $display("FAIL miss_after got combo=%0d score=%0d expected 0/1500", combo, score);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL miss_pending got=%0d outstanding expected=0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_rom();
    rom[0] = {16'd1, 4'b1011};
    do_reset();
    begin_chart();
    repeat (109) tick();
    exp_q.push_back(2'd1);
    frame_tick = 1'b1;
    key_press  = 4'b1010;
    cycle();
    frame_tick = 1'b0;
    key_press  = 4'd0;
    checks++;
    if (score !== 20'd600 || combo !== 10'd2) begin
      errors++;
      $display("FAIL dual_score got score=%0d combo=%0d expected 600/2", score, combo);
    end
    checks++;
    if (track0 !== rows(436, 451) || (track1 | track2 | track3) !== '0) begin
      errors++;
      $display("FAIL dual_tracks got track0=%h others_zero=%0b expected rows 436..451 and 1",
               track0, (track1 | track2 | track3) == '0);
    end
    cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL dual_pending got=%0d outstanding expected=0", exp_q.size());
    end
  endtask

  task automatic test_done_stop();
    clear_rom();
    rom[0] = {16'd2, 4'b0001};
    rom[1] = {16'd4, 4'b0100};
    do_reset();
    begin_chart();
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    for (int n = 0; n < 200 && !done; n++) tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rom_addr !== 10'd2) begin
      errors++;
      $display("FAIL done_state got done=%0b busy=%0b addr=%0d expected 1/0/2", done, busy, rom_addr);
    end
    checks++;
    if (exp_q.size() != 0 || combo !== 10'd0) begin
      errors++;
      $display("FAIL done_misses got outstanding=%0d combo=%0d expected 0/0", exp_q.size(), combo);
    end
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_from_done got done=%0b busy=%0b expected 0/0", done, busy);
    end
    rom[0] = {16'd1, 4'b1111};
    rom[1] = 20'h0;
    rom[2] = 20'h0;
    begin_chart();
    repeat (3) tick();
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (track0 !== rows(8, 23) || rom_addr !== 10'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored got track0=%h addr=%0d busy=%0b expected rows 8..23/1/1",
               track0, rom_addr, busy);
    end
    stop       = 1'b1;
    frame_tick = 1'b1;
    key_press  = 4'b1111;
    cycle();
    stop       = 1'b0;
    frame_tick = 1'b0;
    key_press  = 4'd0;
    checks++;
    if ((track0 | track1 | track2 | track3) !== '0 || busy !== 1'b0 || judge_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_run got tracks_zero=%0b busy=%0b jv=%0b expected 1/0/0",
               (track0 | track1 | track2 | track3) == '0, busy, judge_valid);
    end
    cycle();
  endtask

  initial begin
    rst        = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    key_press  = 4'd0;
    clear_rom();
    test_reset();
    test_spawn();
    test_perfect();
    test_good_and_ignored();
    test_miss();
    test_back_to_back();
    test_done_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
